uart_rx_word_ctrl: RTL and testbench

UART_RX_WORD_CTRL -- requirements
Module: uart_rx_word_ctrl

---
 rtl/uart_rx_word_ctrl.sv | 166 ++++++++++++++++
 tb/tb_uart_rx_word_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_word_ctrl.sv
// uart_rx_word_ctrl
// Takes packed words from a UART byte packer, acknowledges each one with a
// single-cycle pk_ack pulse, and queues the accepted words for a CPU to read.
//
// Ports
//   clk, rst_n      system clock, asynchronous active-low reset
//   pk_irq          packer word-ready pulse (sampled only in IDLE)
//   pk_data         packed bytes, first byte in [31:24]
//   pk_num          valid byte count 1..4 (only [2:0] stored)
//   pk_frame_err    packer framing error, stored with the word
//   pk_ack          one-cycle release pulse back to the packer
//   ctl_en          enables queueing and irq
//   ctl_flush       empties the queue (deferred while a word is in flight)
//   ovf_clr         clears the sticky overflow flag
//   rd_req          CPU pop strobe, ignored while empty
//   rd_valid        queue non-empty
//   rd_data/num/err head entry, shown combinationally from storage
//   level           current entry count
//   irq             registered (ctl_en && level >= IRQ_LVL)
//   ovf             sticky overflow flag
module uart_rx_word_ctrl #(
  parameter int DEPTH   = 4,
  parameter int IRQ_LVL = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       pk_irq,
  input  logic [31:0]                pk_data,
  input  logic [31:0]                pk_num,
  input  logic                       pk_frame_err,
  output logic                       pk_ack,
  input  logic                       ctl_en,
  input  logic                       ctl_flush,
  input  logic                       ovf_clr,
  input  logic                       rd_req,
  output logic                       rd_valid,
  output logic [31:0]                rd_data,
  output logic [2:0]                 rd_num,
  output logic                       rd_err,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       irq,
  output logic                       ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] IRQ_L   = LW'(IRQ_LVL);

  typedef enum logic [1:0] {IDLE, CAPTURE, ACK, FLUSH} state_t;

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  num;
    logic        err;
  } entry_t;

  state_t          state, state_nxt;
  entry_t          mem [DEPTH];
  entry_t          head;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [LW-1:0]   level_q;
  logic            flush_pend;
  logic            irq_q, ovf_q;
  logic            full, pop, push, ovf_evt, cap_ok;

  // Upper count bits carry no information; fold them so they are visibly consumed.
  logic unused_pk_num;
  assign unused_pk_num = ^pk_num[31:3];

  // A pop in the CAPTURE cycle frees a slot, so a full queue can still accept.
  assign full    = (level_q == DEPTH_L);
  assign pop     = rd_req && (level_q != '0) && (state != FLUSH);
  assign cap_ok  = (state == CAPTURE) && ctl_en && !ctl_flush;
  assign push    = cap_ok && (!full || pop);
  assign ovf_evt = cap_ok && full && !pop;

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  // NOTE: the default assignment first keeps every path assigned, so no latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (ctl_flush || flush_pend) state_nxt = FLUSH;
        else if (pk_irq)             state_nxt = CAPTURE;
      end
      CAPTURE: state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      FLUSH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    pk_ack = (state == ACK);
  end

  // Flush requests arriving while a word is in flight wait for IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      flush_pend <= 1'b0;
    else if (state == FLUSH)
      flush_pend <= 1'b0;
    else if (ctl_flush && (state == CAPTURE || state == ACK))
      flush_pend <= 1'b1;
  end

  // Pointers and level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else if (state == FLUSH) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Word storage
  // NOTE: storage has no reset; rd_valid qualifies it, and leaving it
  // unreset lets the array map onto plain registers or RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{data: pk_data, num: pk_num[2:0], err: pk_frame_err};
  end

  // irq follows the registered level, so it trails a push by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      irq_q <= ctl_en && (level_q >= IRQ_L);
      if (ovf_evt)      ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
    end
  end

  assign head     = mem[rd_ptr];
  assign rd_valid = (level_q != '0);
  assign rd_data  = head.data;
  assign rd_num   = head.num;
  assign rd_err   = head.err;
  assign level    = level_q;
  assign irq      = irq_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_uart_rx_word_ctrl.sv
// Testbench for uart_rx_word_ctrl: scoreboard of expected queue entries,
// one task per scenario, inline comparisons.
module tb_uart_rx_word_ctrl;

  localparam int DEPTH   = 4;
  localparam int IRQ_LVL = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pk_irq, pk_frame_err, pk_ack;
  logic [31:0] pk_data, pk_num;
  logic        ctl_en, ctl_flush, ovf_clr, rd_req;
  logic        rd_valid, rd_err, irq, ovf;
  logic [31:0] rd_data;
  logic [2:0]  rd_num;
  logic [2:0]  level;

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  num;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  uart_rx_word_ctrl #(.DEPTH(DEPTH), .IRQ_LVL(IRQ_LVL)) dut (
    .clk(clk), .rst_n(rst_n),
    .pk_irq(pk_irq), .pk_data(pk_data), .pk_num(pk_num), .pk_frame_err(pk_frame_err),
    .pk_ack(pk_ack),
    .ctl_en(ctl_en), .ctl_flush(ctl_flush), .ovf_clr(ovf_clr), .rd_req(rd_req),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_num(rd_num), .rd_err(rd_err),
    .level(level), .irq(irq), .ovf(ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance to 1 time unit after the next rising edge (the next "cycle").
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one word in cycle 0 (FSM in IDLE), returns in cycle 3.
  task automatic send_word(input logic [31:0] d, input logic [2:0] n, input logic e,
                           input bit do_push, input bit pop_cap, input bit flush_cap);
    exp_t t;
    pk_data = d; pk_num = 32'(n); pk_frame_err = e; pk_irq = 1'b1;
    total_cnt++;
    if (pk_ack !== 1'b0) $display("FAIL ack_idle: got %b want 0", pk_ack); else pass_cnt++;
    step();
    pk_irq = 1'b0;
    total_cnt++;
    if (pk_ack !== 1'b0) $display("FAIL ack_capture: got %b want 0", pk_ack); else pass_cnt++;
    if (pop_cap) begin
      total_cnt++;
      if (sb.size() == 0) $display("FAIL pop_cap_sb: scoreboard empty, want an entry");
      else if (rd_valid !== 1'b1 || rd_data !== sb[0].data)
        $display("FAIL pop_cap_head: got v=%b data=%h want v=1 data=%h", rd_valid, rd_data, sb[0].data);
      else pass_cnt++;
      if (sb.size() != 0) t = sb.pop_front();
      rd_req = 1'b1;
    end
    if (flush_cap) ctl_flush = 1'b1;
    step();
    rd_req = 1'b0; ctl_flush = 1'b0;
    if (do_push) begin
      t.data = d; t.num = n; t.err = e;
      sb.push_back(t);
    end
    total_cnt++;
    if (pk_ack !== 1'b1) $display("FAIL ack_pulse: got %b want 1", pk_ack); else pass_cnt++;
    total_cnt++;
    if (int'(level) !== sb.size()) $display("FAIL level_cycle2: got %0d want %0d", level, sb.size());
    else pass_cnt++;
    step();
    total_cnt++;
    if (pk_ack !== 1'b0) $display("FAIL ack_one_cycle: got %b want 0", pk_ack); else pass_cnt++;
  endtask

  // Compares the head against the scoreboard, pops it, checks the new level.
  task automatic pop_check(input string name);
    exp_t t;
    total_cnt++;
    if (sb.size() == 0) begin
      $display("FAIL %s: scoreboard empty, want an entry", name);
    end else begin
      t = sb.pop_front();
      if (rd_valid !== 1'b1 || rd_data !== t.data || rd_num !== t.num || rd_err !== t.err)
        $display("FAIL %s: got v=%b %h/%0d/%b want v=1 %h/%0d/%b", name,
                 rd_valid, rd_data, rd_num, rd_err, t.data, t.num, t.err);
      else pass_cnt++;
    end
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    total_cnt++;
    if (int'(level) !== sb.size()) $display("FAIL %s_level: got %0d want %0d", name, level, sb.size());
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pk_irq = 1'b0; pk_data = '0; pk_num = '0; pk_frame_err = 1'b0;
    ctl_en = 1'b1; ctl_flush = 1'b0; ovf_clr = 1'b0; rd_req = 1'b0;
    #12;
    total_cnt++;
    if ({pk_ack, rd_valid, irq, ovf} !== 4'b0 || level !== 3'd0)
      $display("FAIL reset_outputs: got ack=%b v=%b irq=%b ovf=%b lvl=%0d want all 0",
               pk_ack, rd_valid, irq, ovf, level);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    step(); step();
  endtask

  task automatic test_single_word();
    send_word(32'h4142_4344, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0);
    total_cnt++;
    if (irq !== 1'b1) $display("FAIL single_irq: got %b want 1", irq); else pass_cnt++;
    pop_check("single_head");
    step();
    total_cnt++;
    if (irq !== 1'b0) $display("FAIL single_irq_clear: got %b want 0", irq); else pass_cnt++;
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 5; i++)
      send_word(32'hA000_0000 + 32'(i), 3'((i % 4) + 1), (i == 2), (i < 4), 1'b0, 1'b0);
    total_cnt++;
    if (level !== 3'd4 || ovf !== 1'b1)
      $display("FAIL ovf_full: got lvl=%0d ovf=%b want lvl=4 ovf=1", level, ovf);
    else pass_cnt++;
    total_cnt++;
    if (rd_data !== sb[0].data) $display("FAIL ovf_head: got %h want %h", rd_data, sb[0].data);
    else pass_cnt++;
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    total_cnt++;
    if (ovf !== 1'b0) $display("FAIL ovf_clr: got %b want 0", ovf); else pass_cnt++;
    // Overflow event coinciding with ovf_clr must leave ovf set.
    pk_data = 32'hDEAD_BEEF; pk_num = 32'd1; pk_irq = 1'b1;
    step();
    pk_irq = 1'b0; ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    total_cnt++;
    if (ovf !== 1'b1 || pk_ack !== 1'b1 || level !== 3'd4)
      $display("FAIL ovf_vs_clr: got ovf=%b ack=%b lvl=%0d want 1 1 4", ovf, pk_ack, level);
    else pass_cnt++;
    step();
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    total_cnt++;
    if (ovf !== 1'b0) $display("FAIL ovf_clr2: got %b want 0", ovf); else pass_cnt++;
  endtask

  task automatic test_concurrent_pop();
    send_word(32'h5555_AAAA, 3'd2, 1'b1, 1'b1, 1'b1, 1'b0);
    total_cnt++;
    if (level !== 3'd4 || ovf !== 1'b0)
      $display("FAIL conc_level: got lvl=%0d ovf=%b want 4 0", level, ovf);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) pop_check("conc_drain");
    total_cnt++;
    if (rd_valid !== 1'b0) $display("FAIL conc_empty: got %b want 0", rd_valid); else pass_cnt++;
  endtask

  task automatic test_disable_flush();
    ctl_en = 1'b0;
    send_word(32'hBAD0_0001, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    total_cnt++;
    if (level !== 3'd0 || irq !== 1'b0) $display("FAIL dis_drop: got lvl=%0d irq=%b want 0 0", level, irq);
    else pass_cnt++;
    ctl_en = 1'b1;
    for (int i = 0; i < 3; i++) send_word(32'hC000_0000 + 32'(i), 3'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    ctl_flush = 1'b1;
    step();
    ctl_flush = 1'b0;
    step();
    sb.delete();
    total_cnt++;
    if (level !== 3'd0 || rd_valid !== 1'b0)
      $display("FAIL flush_idle: got lvl=%0d v=%b want 0 0", level, rd_valid);
    else pass_cnt++;
    // Flush during CAPTURE: word dropped, flush serviced after ACK.
    for (int i = 0; i < 2; i++) send_word(32'hD000_0000 + 32'(i), 3'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    send_word(32'hD000_00FF, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(); step();
    sb.delete();
    total_cnt++;
    if (level !== 3'd0 || rd_valid !== 1'b0)
      $display("FAIL flush_pending: got lvl=%0d v=%b want 0 0", level, rd_valid);
    else pass_cnt++;
  endtask

  task automatic test_reset_in_ack();
    pk_data = 32'h1234_5678; pk_num = 32'd2; pk_irq = 1'b1;
    step();
    pk_irq = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({pk_ack, rd_valid, irq, ovf} !== 4'b0 || level !== 3'd0)
      $display("FAIL rst_ack_outputs: got ack=%b v=%b irq=%b ovf=%b lvl=%0d want all 0",
               pk_ack, rd_valid, irq, ovf, level);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    total_cnt++;
    if (pk_ack !== 1'b0 || level !== 3'd0)
      $display("FAIL rst_ack_after: got ack=%b lvl=%0d want 0 0", pk_ack, level);
    else pass_cnt++;
    send_word(32'h8765_4321, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    pop_check("rst_next_word");
  endtask

  task automatic test_empty_pop();
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    total_cnt++;
    if (level !== 3'd0 || rd_valid !== 1'b0)
      $display("FAIL empty_pop: got lvl=%0d v=%b want 0 0", level, rd_valid);
    else pass_cnt++;
    send_word(32'h0BAD_F00D, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0);
    send_word(32'h1357_9BDF, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    pop_check("empty_pop_first");
    pop_check("empty_pop_second");
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_overflow();
    test_concurrent_pop();
    test_disable_flush();
    test_reset_in_ack();
    test_empty_pop();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
